// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the load/store memory stage: access size,
// FSM state, byte-enable generation and alignment checking.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        BYTE  = 2'b00,
        HALF  = 2'b01,
        WORD  = 2'b10,
        DWORD = 2'b11
    } mem_size_e;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DONE,
        DRAIN
    } state_e;

    // Byte enables for up to an 8-byte lane; callers truncate to their width.
    function automatic logic [7:0] be_gen(mem_size_e size, logic [2:0] off);
        case (size)
            BYTE:    be_gen = 8'h01 << off;
            HALF:    be_gen = 8'h03 << off;
            WORD:    be_gen = 8'h0F << off;
            default: be_gen = 8'hFF;
        endcase
    endfunction

    function automatic logic misaligned(mem_size_e size, logic [2:0] off, int data_w);
        case (size)
            BYTE:    misaligned = 1'b0;
            HALF:    misaligned = off[0];
            WORD:    misaligned = (off[1:0] != 2'b00);
            default: misaligned = (data_w == 32) || (off != 3'b000);
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_ls_if.sv
// Data cache channel: valid/ready request, valid-only response.
interface mem_stage_ls_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/mem_load_align.sv
// Combinational load formatter: shift the addressed field down to bit 0,
// then sign- or zero-extend it to the full data width.
module mem_load_align
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]            rdata_i,
    input  logic [$clog2(DATA_W/8)-1:0]  off_i,
    input  mem_size_e                    size_i,
    input  logic                         signed_i,
    output logic [DATA_W-1:0]            data_o
);
    logic [DATA_W-1:0] shifted;
    logic              sign;
    int                width;

    always_comb begin
        shifted = rdata_i >> {off_i, 3'b000};
        width   = DATA_W;
        sign    = 1'b0;
        case (size_i)
            BYTE:    begin width = 8;  sign = shifted[7];  end
            HALF:    begin width = 16; sign = shifted[15]; end
            WORD:    begin width = 32; sign = shifted[31]; end
            default: begin width = DATA_W; sign = shifted[DATA_W-1]; end
        endcase
        sign   = sign & signed_i;
        data_o = '0;
        for (int i = 0; i < DATA_W; i++) begin
            data_o[i] = (i < width) ? shifted[i] : sign;
        end
    end
endmodule

// File: rtl/mem_stage_ls.sv
// Load/store memory stage: issues one cache access at a time, stalls upstream
// while it is in flight, and registers the writeback fields.
module mem_stage_ls
    import mem_stage_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int REG_SEL_W = 5,
    parameter int WB_SEL_W  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  stall_i,
    input  logic                  mem_read_en_i,
    input  logic                  mem_write_en_i,
    input  logic [1:0]            mem_size_i,
    input  logic                  mem_signed_i,
    input  logic                  reg_write_en_i,
    input  logic [WB_SEL_W-1:0]   wb_sel_i,
    input  logic [REG_SEL_W-1:0]  write_reg_sel_i,
    input  logic [DATA_W-1:0]     result_i,
    input  logic [DATA_W-1:0]     cout_i,
    input  logic [DATA_W-1:0]     store_data_i,
    mem_stage_ls_if.master        cache,
    output logic                  stall_o,
    output logic                  reg_write_en_o,
    output logic [WB_SEL_W-1:0]   wb_sel_o,
    output logic [REG_SEL_W-1:0]  write_reg_sel_o,
    output logic [DATA_W-1:0]     result_o,
    output logic [DATA_W-1:0]     cout_o,
    output logic [DATA_W-1:0]     read_data_o,
    output logic                  misalign_o
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [NB-1:0]     be_q, be_d;
    logic [OFF_W-1:0]  off_q;
    mem_size_e         size_q, size_in;
    logic              we_q, signed_q;
    logic [DATA_W-1:0] hold_q, fmt_data, read_data_d;
    logic [2:0]        off3;
    logic              is_mem, mis, start, cap_req, cap_rsp, pipe_en;

    always_comb begin
        size_in = mem_size_e'(mem_size_i);
        off3    = '0;
        off3[OFF_W-1:0] = result_i[OFF_W-1:0];
        is_mem  = mem_read_en_i | mem_write_en_i;
        mis     = is_mem & misaligned(size_in, off3, DATA_W);
        start   = is_mem & ~mis & ~flush_i;
    end

    // Request fields: aligned address, lane-replicated store operand.
    always_comb begin
        addr_d = result_i[ADDR_W-1:0];
        addr_d[OFF_W-1:0] = '0;
        be_d    = NB'(be_gen(size_in, off3));
        wdata_d = '0;
        for (int i = 0; i < NB; i++) begin
            case (size_in)
                BYTE:    wdata_d[8*i +: 8] = store_data_i[7:0];
                HALF:    wdata_d[8*i +: 8] = store_data_i[8*(i%2) +: 8];
                WORD:    wdata_d[8*i +: 8] = store_data_i[8*(i%4) +: 8];
                default: wdata_d[8*i +: 8] = store_data_i[8*i +: 8];
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        cap_req = 1'b0;
        cap_rsp = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                    stall_o = 1'b1;
                    cap_req = 1'b1;
                end
            end
            REQ: begin
                stall_o = 1'b1;
                if (flush_i)              state_d = IDLE;
                else if (cache.req_ready) state_d = we_q ? DONE : WAIT;
            end
            WAIT: begin
                stall_o = 1'b1;
                if (flush_i) begin
                    state_d = cache.rsp_valid ? IDLE : DRAIN;
                end else if (cache.rsp_valid) begin
                    cap_rsp = 1'b1;
                    state_d = DONE;
                end
            end
            DRAIN: begin
                stall_o = 1'b1;
                if (cache.rsp_valid) state_d = IDLE;
            end
            DONE: begin
                if (flush_i || !stall_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    mem_load_align #(.DATA_W(DATA_W)) u_align (
        .rdata_i  (cache.rsp_rdata),
        .off_i    (off_q),
        .size_i   (size_q),
        .signed_i (signed_q),
        .data_o   (fmt_data)
    );

    assign pipe_en     = ~stall_i & ~stall_o;
    assign read_data_d = (state_q == DONE && !we_q) ? hold_q : '0;

    assign cache.req_valid = (state_q == REQ);
    assign cache.req_we    = we_q;
    assign cache.req_addr  = addr_q;
    assign cache.req_wdata = wdata_q;
    assign cache.req_be    = be_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            wdata_q         <= '0;
            be_q            <= '0;
            off_q           <= '0;
            size_q          <= BYTE;
            we_q            <= 1'b0;
            signed_q        <= 1'b0;
            hold_q          <= '0;
            reg_write_en_o  <= 1'b0;
            wb_sel_o        <= '0;
            write_reg_sel_o <= '0;
            result_o        <= '0;
            cout_o          <= '0;
            read_data_o     <= '0;
            misalign_o      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cap_req) begin
                addr_q   <= addr_d;
                wdata_q  <= wdata_d;
                be_q     <= be_d;
                off_q    <= result_i[OFF_W-1:0];
                size_q   <= size_in;
                we_q     <= mem_write_en_i;
                signed_q <= mem_signed_i;
            end
            if (cap_rsp) hold_q <= fmt_data;
            // Flush beats stall; stall beats capture.
            if (flush_i) begin
                reg_write_en_o  <= 1'b0;
                wb_sel_o        <= '0;
                write_reg_sel_o <= '0;
                result_o        <= '0;
                cout_o          <= '0;
                read_data_o     <= '0;
                misalign_o      <= 1'b0;
            end else if (pipe_en) begin
                reg_write_en_o  <= reg_write_en_i & ~mis;
                wb_sel_o        <= wb_sel_i;
                write_reg_sel_o <= write_reg_sel_i;
                result_o        <= result_i;
                cout_o          <= cout_i;
                read_data_o     <= read_data_d;
                misalign_o      <= mis;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_ls.sv
// Self-checking bench for mem_stage_ls: the bench plays the data cache and
// scores retired instructions against a queue of expected writeback values.
module tb_mem_stage_ls;
    import mem_stage_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst, flush, stall, rd_en, wr_en, sgn, rwe;
    logic [1:0]    size, wbs;
    logic [4:0]    wrs;
    logic [DW-1:0] res, cout, sdata;
    logic          stall_o, rwe_o, mis_o;
    logic [1:0]    wbs_o;
    logic [4:0]    wrs_o;
    logic [DW-1:0] res_o, cout_o, rdata_o;

    always #5 clk = ~clk;

    mem_stage_ls_if #(.DATA_W(DW), .ADDR_W(AW)) cache_if ();

    mem_stage_ls #(.DATA_W(DW), .ADDR_W(AW), .REG_SEL_W(5), .WB_SEL_W(2)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .stall_i(stall),
        .mem_read_en_i(rd_en), .mem_write_en_i(wr_en), .mem_size_i(size),
        .mem_signed_i(sgn), .reg_write_en_i(rwe), .wb_sel_i(wbs),
        .write_reg_sel_i(wrs), .result_i(res), .cout_i(cout), .store_data_i(sdata),
        .cache(cache_if), .stall_o(stall_o), .reg_write_en_o(rwe_o),
        .wb_sel_o(wbs_o), .write_reg_sel_o(wrs_o), .result_o(res_o),
        .cout_o(cout_o), .read_data_o(rdata_o), .misalign_o(mis_o)
    );

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        logic        rwe;
        logic [4:0]  sel;
        logic [31:0] res;
        logic [31:0] cout;
    } exp_t;

    exp_t sb[$];
    int   cmp  = 0;
    int   errs = 0;

    function automatic logic [31:0] m_load(logic [1:0] sz, logic sg, logic [1:0] off, logic [31:0] d);
        logic [31:0] f;
        f = d >> (8 * off);
        case (sz)
            2'd0:    return sg ? {{24{f[7]}}, f[7:0]}   : {24'h0, f[7:0]};
            2'd1:    return sg ? {{16{f[15]}}, f[15:0]} : {16'h0, f[15:0]};
            default: return f;
        endcase
    endfunction

    function automatic logic [3:0] m_be(logic [1:0] sz, logic [1:0] off);
        case (sz)
            2'd0:    return 4'b0001 << off;
            2'd1:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(logic [1:0] sz, logic [31:0] d);
        case (sz)
            2'd0:    return {4{d[7:0]}};
            2'd1:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    task automatic set_nop();
        rd_en = 0; wr_en = 0; size = 0; sgn = 0; rwe = 0; wbs = 0; wrs = 0;
        res = 0; cout = 0; sdata = 0; flush = 0;
    endtask

    // Drives one instruction, acts as cache, then scores its retirement.
    task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdata,
                          input int rdy_dly, input int hold_n, output int stalls);
        exp_t        e, got;
        logic        mis;
        int          reqc, acc, holds, exp_st;
        bit          done;
        logic [31:0] rd_before;
        mis = (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 0) || (sz == 2'd3);
        e.mis = mis; e.rwe = rd & ~mis; e.sel = addr[6:2]; e.res = addr; e.cout = ~addr;
        e.rd  = (rd && !mis) ? m_load(sz, sg, addr[1:0], rdata) : 32'h0;
        sb.push_back(e);
        rd_en = rd; wr_en = wr; size = sz; sgn = sg; rwe = rd; wbs = 2'b01;
        wrs = addr[6:2]; res = addr; cout = ~addr; sdata = sd;
        stalls = 0; reqc = 0; acc = -1; holds = 0; done = 0; rd_before = rdata_o;
        for (int c = 0; c < 100 && !done; c++) begin
            #1;
            if (cache_if.req_valid) begin
                cmp++;
                if ({cache_if.req_we, cache_if.req_addr, cache_if.req_be, cache_if.req_wdata} !==
                    {wr, addr & ~32'h3, m_be(sz, addr[1:0]), m_wdata(sz, sd)}) begin
                    errs++;
                    $display("FAIL req_fields addr=%h: got we=%b a=%h be=%h wd=%h, want we=%b a=%h be=%h wd=%h",
                             addr, cache_if.req_we, cache_if.req_addr, cache_if.req_be, cache_if.req_wdata,
                             wr, addr & ~32'h3, m_be(sz, addr[1:0]), m_wdata(sz, sd));
                end
                if (reqc == rdy_dly) begin cache_if.req_ready = 1; acc = c; end
                reqc++;
            end
            if (rd && acc >= 0 && c == acc + 1) begin
                cache_if.rsp_valid = 1; cache_if.rsp_rdata = rdata;
            end
            if (stall_o) stalls++;
            else begin
                if (holds > 0) begin
                    cmp++;
                    if (rdata_o !== rd_before) begin
                        errs++;
                        $display("FAIL hold_read_data: got %h, want %h", rdata_o, rd_before);
                    end
                end
                if (holds < hold_n) begin stall = 1; holds++; end
                else begin stall = 0; done = 1; end
            end
            @(posedge clk); #1;
            cache_if.req_ready = 0; cache_if.rsp_valid = 0; cache_if.rsp_rdata = $urandom;
        end
        set_nop();
        stall = 0;
        cmp++;
        if (!done) begin errs++; $display("FAIL timeout addr=%h: no retirement within budget", addr); end
        exp_st = mis ? 0 : (2 + rdy_dly + (rd ? 1 : 0));
        cmp++;
        if (stalls !== exp_st || reqc !== (mis ? 0 : rdy_dly + 1)) begin
            errs++;
            $display("FAIL stall_count addr=%h: got stalls=%0d reqs=%0d, want stalls=%0d reqs=%0d",
                     addr, stalls, reqc, exp_st, mis ? 0 : rdy_dly + 1);
        end
        got = sb.pop_front();
        cmp++;
        if (rdata_o !== got.rd) begin
            errs++; $display("FAIL read_data addr=%h: got %h, want %h", addr, rdata_o, got.rd);
        end
        cmp++;
        if ({mis_o, rwe_o, wrs_o, res_o, cout_o, wbs_o} !== {got.mis, got.rwe, got.sel, got.res, got.cout, 2'b01}) begin
            errs++;
            $display("FAIL wb_fields addr=%h: got mis=%b rwe=%b sel=%h res=%h cout=%h wb=%b, want mis=%b rwe=%b sel=%h res=%h cout=%h wb=01",
                     addr, mis_o, rwe_o, wrs_o, res_o, cout_o, wbs_o, got.mis, got.rwe, got.sel, got.res, got.cout);
        end
    endtask

    task automatic test_reset();
        cmp++;
        if ({cache_if.req_valid, stall_o, rwe_o, mis_o, res_o, rdata_o, cout_o, wrs_o, wbs_o} !== '0) begin
            errs++;
            $display("FAIL reset_state: got rv=%b st=%b rwe=%b mis=%b res=%h rd=%h, want all 0",
                     cache_if.req_valid, stall_o, rwe_o, mis_o, res_o, rdata_o);
        end
    endtask

    task automatic test_store();
        int st;
        run_op(0, 1, 2'd2, 0, 32'h104, 32'hDEADBEEF, 32'h0, 0, 0, st);
        run_op(0, 1, 2'd0, 0, 32'h101, 32'h000000AB, 32'h0, 0, 0, st);
        run_op(0, 1, 2'd1, 0, 32'h102, 32'h00001234, 32'h0, 1, 0, st);
    endtask

    task automatic test_load_ext();
        int st;
        run_op(1, 0, 2'd0, 1, 32'h103, 32'hDEADBEEF, 32'h80112233, 0, 0, st);
        cmp++;
        if (rdata_o !== 32'hFFFFFF80) begin errs++; $display("FAIL sbyte_const: got %h, want ffffff80", rdata_o); end
        run_op(1, 0, 2'd0, 0, 32'h103, 32'h0, 32'h80112233, 0, 0, st);
        cmp++;
        if (rdata_o !== 32'h00000080) begin errs++; $display("FAIL ubyte_const: got %h, want 00000080", rdata_o); end
        run_op(1, 0, 2'd1, 1, 32'h102, 32'h0, 32'h8001_7FFF, 0, 0, st);
        run_op(1, 0, 2'd2, 1, 32'h108, 32'h0, 32'hCAFEF00D, 0, 0, st);
    endtask

    task automatic test_misalign();
        int st;
        run_op(1, 0, 2'd1, 0, 32'h101, 32'h0, 32'h0, 0, 0, st);
        run_op(1, 0, 2'd3, 0, 32'h100, 32'h0, 32'h0, 0, 0, st);
        run_op(0, 1, 2'd2, 0, 32'h102, 32'h55AA55AA, 32'h0, 0, 0, st);
    endtask

    task automatic test_flush_wait();
        int st;
        rd_en = 1; size = 2'd2; rwe = 1; wbs = 2'b01; wrs = 5'd7; res = 32'h200; cout = 32'h1;
        #1; @(posedge clk); #1;                 // REQ
        cache_if.req_ready = 1;
        @(posedge clk); #1;                     // WAIT: flush it
        cache_if.req_ready = 0;
        set_nop(); flush = 1;
        @(posedge clk); #1;                     // DRAIN
        flush = 0;
        for (int c = 0; c < 3; c++) begin       // response lands 4 cycles after acceptance
            if (c == 2) begin cache_if.rsp_valid = 1; cache_if.rsp_rdata = 32'h12345678; end
            #1;
            cmp++;
            if (stall_o !== 1'b1) begin errs++; $display("FAIL drain_stall c=%0d: got %b, want 1", c, stall_o); end
            @(posedge clk); #1;
            cache_if.rsp_valid = 0;
        end
        #1;
        cmp++;
        if ({stall_o, cache_if.req_valid, rwe_o, res_o, rdata_o, mis_o} !== '0) begin
            errs++;
            $display("FAIL flush_outputs: got st=%b rv=%b rwe=%b res=%h rd=%h mis=%b, want all 0",
                     stall_o, cache_if.req_valid, rwe_o, res_o, rdata_o, mis_o);
        end
        run_op(1, 0, 2'd2, 0, 32'h204, 32'h0, 32'h0BADF00D, 0, 0, st);
    endtask

    task automatic test_ready_hold();
        int st;
        run_op(1, 0, 2'd2, 0, 32'h300, 32'h0, 32'h13579BDF, 5, 3, st);
    endtask

    task automatic test_reset_in_req();
        int st;
        wr_en = 1; size = 2'd2; res = 32'h400; sdata = 32'hA5A5A5A5; wbs = 2'b01;
        #1; @(posedge clk); #1;                 // REQ
        cmp++;
        if (cache_if.req_valid !== 1'b1) begin errs++; $display("FAIL rst_pre_req: got %b, want 1", cache_if.req_valid); end
        set_nop(); rst = 1;
        @(posedge clk); #1;
        rst = 0; #1;
        cmp++;
        if ({cache_if.req_valid, stall_o, rwe_o, mis_o, res_o, rdata_o, cache_if.req_addr, cache_if.req_be} !== '0) begin
            errs++;
            $display("FAIL rst_in_req: got rv=%b st=%b res=%h rd=%h addr=%h be=%h, want all 0",
                     cache_if.req_valid, stall_o, res_o, rdata_o, cache_if.req_addr, cache_if.req_be);
        end
        @(posedge clk); #1;
        run_op(0, 1, 2'd2, 0, 32'h404, 32'h01020304, 32'h0, 0, 0, st);
    endtask

    task automatic test_back_to_back();
        int          st;
        logic [1:0]  sz;
        logic [31:0] a;
        logic        ld;
        for (int i = 0; i < 8; i++) begin
            sz = 2'($urandom_range(0, 2));
            a  = 32'h500 + 32'(4 * i);
            if (sz == 2'd0) a[1:0] = 2'($urandom_range(0, 3));
            if (sz == 2'd1) a[1]   = 1'($urandom_range(0, 1));
            ld = 1'($urandom_range(0, 1));
            run_op(ld, ~ld, sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                   $urandom_range(0, 2), 0, st);
        end
    endtask

    initial begin
        set_nop();
        stall = 0; rst = 1;
        cache_if.req_ready = 0; cache_if.rsp_valid = 0; cache_if.rsp_rdata = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        #1;
        test_reset();
        test_store();
        test_load_ext();
        test_misalign();
        test_flush_wait();
        test_ready_hold();
        test_reset_in_req();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
